// File: rtl/fp_cluster_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fp_cluster_pkg
//  Description : Shared constants and FSM encodings for the FP add/sub
//                cluster (issue controller and adder wrapper).
//  Revision    : 1.0 - initial release
// ============================================================================
package fp_cluster_pkg;

  // IEEE-754 single precision operand width
  localparam int FP_WIDTH = 32;

  // Cycles from registered adder operands to wrapper result valid
  localparam int DEFAULT_ADD_LATENCY = 4;

  // Issue controller states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } issue_state_t;

endpackage
`default_nettype wire

// File: rtl/valid_tag_delay.sv
`default_nettype none
// ============================================================================
//  Module      : valid_tag_delay
//  Description : DEPTH-stage shift line of {valid, tag} pairs with synchronous
//                clear. Reports whether anything is still in flight ahead of
//                the final stage so the owner can tell when the line drains.
//  Revision    : 1.0 - initial release
// ============================================================================
module valid_tag_delay #(
  parameter int DEPTH = 5,   // must be >= 2
  parameter int TAG_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_en,
  input  logic             in_valid,
  input  logic [TAG_W-1:0] in_tag,
  output logic             pending,
  output logic             out_valid,
  output logic [TAG_W-1:0] out_tag
);

  logic [DEPTH-1:0] stage_valid;
  logic [TAG_W-1:0] stage_tag [DEPTH];

  // Shift the line one stage per enabled cycle, inserting at stage 0
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_valid <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        stage_tag[i] <= '0;
      end
    end else if (shift_en) begin
      stage_valid  <= {stage_valid[DEPTH-2:0], in_valid};
      stage_tag[0] <= in_tag;
      for (int i = 1; i < DEPTH; i++) begin
        stage_tag[i] <= stage_tag[i-1];
      end
    end
  end

  // Anything not yet in the last stage means the line will not be empty next cycle
  assign pending   = |stage_valid[DEPTH-2:0];
  assign out_valid = stage_valid[DEPTH-1];
  assign out_tag   = stage_tag[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/fp_addsub_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fp_addsub_issue_ctrl
//  Description : Issue stage for the FP adder/subtractor. Pulls vec_len
//                operand pairs jointly from two ready/valid streams, drives
//                registered adder operands, and tracks each issued pair
//                through a latency-matched token line so res_strobe fires
//                exactly when that pair's result is valid.
//                Optional macro FP_ISSUE_STATS_EN adds the stall_cycles port.
//  Revision    : 1.0 - initial release
// ============================================================================
module fp_addsub_issue_ctrl
  import fp_cluster_pkg::*;
#(
  parameter int ADD_LATENCY = DEFAULT_ADD_LATENCY,  // must be >= 1
  parameter int LEN_W       = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [LEN_W-1:0]    vec_len,
  input  logic                op_in,
  input  logic                a_valid,
  input  logic [FP_WIDTH-1:0] a_data,
  output logic                a_ready,
  input  logic                b_valid,
  input  logic [FP_WIDTH-1:0] b_data,
  output logic                b_ready,
  output logic [FP_WIDTH-1:0] add_A,
  output logic [FP_WIDTH-1:0] add_B,
  output logic                add_op,
  output logic                add_ce,
  output logic                res_strobe,
  output logic [LEN_W-1:0]    res_index,
  output logic                busy,
  output logic                done
`ifdef FP_ISSUE_STATS_EN
  ,
  output logic [15:0]         stall_cycles
`endif
);

  // One stage per adder pipeline cycle plus the operand register stage
  localparam int TOKEN_DEPTH = ADD_LATENCY + 1;

  issue_state_t     state;
  issue_state_t     state_nxt;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] count_q;
  logic             start_accept;
  logic             fire;
  logic             last_fire;
  logic             token_pending;
  logic             in_issue;

  assign in_issue     = (state == ST_ISSUE);
  assign start_accept = (state == ST_IDLE) && start;
  assign fire         = in_issue && a_valid && b_valid;
  assign last_fire    = fire && (count_q == (len_q - 1'b1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; DRAIN leaves when the final token sits in the last stage
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = (vec_len != '0) ? ST_ISSUE : ST_DONE;
        end
      end
      ST_ISSUE: begin
        if (last_fire) begin
          state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!token_pending) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Handshake and status outputs decoded from state
  always_comb begin
    a_ready = in_issue && b_valid;
    b_ready = in_issue && a_valid;
    busy    = (state != ST_IDLE);
    add_ce  = (state != ST_IDLE);
    done    = (state == ST_DONE);
  end

  // Vector length and operation captured at an accepted start
  always_ff @(posedge clk) begin
    if (rst) begin
      len_q  <= '0;
      add_op <= 1'b0;
    end else if (start_accept) begin
      len_q  <= vec_len;
      add_op <= op_in;
    end
  end

  // Element counter: index of the next pair to issue
  always_ff @(posedge clk) begin
    if (rst || start_accept) begin
      count_q <= '0;
    end else if (fire) begin
      count_q <= count_q + 1'b1;
    end
  end

  // Operand registers load on fire and otherwise hold
  always_ff @(posedge clk) begin
    if (rst) begin
      add_A <= '0;
      add_B <= '0;
    end else if (fire) begin
      add_A <= a_data;
      add_B <= b_data;
    end
  end

  // Token line: bubbles insert zero tags so res_index stays clean between results
  valid_tag_delay #(
    .DEPTH (TOKEN_DEPTH),
    .TAG_W (LEN_W)
  ) u_token_line (
    .clk       (clk),
    .rst       (rst),
    .shift_en  (busy),
    .in_valid  (fire),
    .in_tag    (fire ? count_q : '0),
    .pending   (token_pending),
    .out_valid (res_strobe),
    .out_tag   (res_index)
  );

`ifdef FP_ISSUE_STATS_EN
  // Count ISSUE cycles that did not fire; saturating, held until the next start
  always_ff @(posedge clk) begin
    if (rst || start_accept) begin
      stall_cycles <= '0;
    end else if (in_issue && !fire && (stall_cycles != 16'hFFFF)) begin
      stall_cycles <= stall_cycles + 16'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fp_addsub_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fp_addsub_issue_ctrl
//  Description : Self-checking bench for fp_addsub_issue_ctrl. A table of
//                vector operations is replayed cycle by cycle against a small
//                timing model; reset corner cases are hand-written sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_addsub_issue_ctrl;

  localparam int          LAT   = 4;
  localparam int          LW    = 10;
  localparam logic [31:0] B_VAL = 32'h3F00_0000;  // 0.5

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [LW-1:0] vec_len = '0;
  logic          op_in = 1'b0;
  logic          a_valid = 1'b0;
  logic [31:0]   a_data = '0;
  logic          a_ready;
  logic          b_valid = 1'b0;
  logic [31:0]   b_data = '0;
  logic          b_ready;
  logic [31:0]   add_A;
  logic [31:0]   add_B;
  logic          add_op;
  logic          add_ce;
  logic          res_strobe;
  logic [LW-1:0] res_index;
  logic          busy;
  logic          done;
`ifdef FP_ISSUE_STATS_EN
  logic [15:0]   stall_cycles;
`endif

  int checks   = 0;
  int failures = 0;

  // Model of the registered outputs carried across vectors
  logic [31:0] m_a  = '0;
  logic [31:0] m_b  = '0;

  fp_addsub_issue_ctrl #(
    .ADD_LATENCY (LAT),
    .LEN_W       (LW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .vec_len    (vec_len),
    .op_in      (op_in),
    .a_valid    (a_valid),
    .a_data     (a_data),
    .a_ready    (a_ready),
    .b_valid    (b_valid),
    .b_data     (b_data),
    .b_ready    (b_ready),
    .add_A      (add_A),
    .add_B      (add_B),
    .add_op     (add_op),
    .add_ce     (add_ce),
    .res_strobe (res_strobe),
    .res_index  (res_index),
    .busy       (busy),
    .done       (done)
`ifdef FP_ISSUE_STATS_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  // One vector op: inputs plus hand-computed results
  typedef struct {
    int len;         // vec_len
    int op;          // op_in
    int bub;         // element index after which b_valid drops
    int nb;          // number of b_valid-low cycles (0 = none)
    int restart;     // cycle to pulse an ignored start (0 = none)
    int exp_strobes; // total res_strobe cycles
    int exp_done;    // cycle (relative to start) of the done pulse
    int exp_stall;   // stall_cycles at done
  } vec_t;

  function automatic logic [31:0] a_val(input int i);
    case (i)
      0:       return 32'h3F80_0000;  // 1.0
      1:       return 32'h4000_0000;  // 2.0
      2:       return 32'h4040_0000;  // 3.0
      3:       return 32'h4080_0000;  // 4.0
      4:       return 32'h40A0_0000;  // 5.0
      5:       return 32'h40C0_0000;  // 6.0
      6:       return 32'h40E0_0000;  // 7.0
      7:       return 32'h4100_0000;  // 8.0
      default: return 32'h4110_0000;  // 9.0
    endcase
  endfunction

  // Cycle (relative to the start cycle) on which element i fires
  function automatic int fire_cyc(input int i, input int bub, input int nb);
    return 1 + i + ((nb > 0 && i > bub) ? nb : 0);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " add_A"}, add_A, 32'd0);
    chk({tag, " add_B"}, add_B, 32'd0);
    chk({tag, " add_op"}, 32'(add_op), 32'd0);
    chk({tag, " add_ce"}, 32'(add_ce), 32'd0);
    chk({tag, " res_strobe"}, 32'(res_strobe), 32'd0);
    chk({tag, " res_index"}, 32'(res_index), 32'd0);
    chk({tag, " busy"}, 32'(busy), 32'd0);
    chk({tag, " done"}, 32'(done), 32'd0);
    chk({tag, " a_ready"}, 32'(a_ready), 32'd0);
    chk({tag, " b_ready"}, 32'(b_ready), 32'd0);
`ifdef FP_ISSUE_STATS_EN
    chk({tag, " stall_cycles"}, 32'(stall_cycles), 32'd0);
`endif
  endtask

  // Replay one vector op and compare every output each cycle against the model
  task automatic run_vec(input int id, input vec_t v);
    int    nstrobe;
    int    nf;
    int    last_f;
    int    exp_idx;
    logic  bv;
    logic  exp_strobe;
    string t;
    last_f  = (v.len > 0) ? fire_cyc(v.len - 1, v.bub, v.nb) : 0;
    nstrobe = 0;
    @(posedge clk); #1;
    start   = 1'b1;
    vec_len = LW'(v.len);
    op_in   = v.op[0];
    a_valid = 1'b1;
    b_valid = 1'b1;
    a_data  = a_val(0);
    b_data  = B_VAL;
    @(negedge clk);
    chk($sformatf("v%0d c0 busy", id), 32'(busy), 32'd0);
    chk($sformatf("v%0d c0 a_ready", id), 32'(a_ready), 32'd0);
    for (int c = 1; c <= v.exp_done + 1; c++) begin
      @(posedge clk); #1;
      start   = (v.restart != 0) && (c == v.restart);
      vec_len = start ? LW'(1) : '0;
      op_in   = start;
      nf = 0;
      for (int i = 0; i < v.len; i++) begin
        if (fire_cyc(i, v.bub, v.nb) < c) nf++;
      end
      bv = !(v.nb > 0 && c > fire_cyc(v.bub, v.bub, v.nb) &&
             c <= fire_cyc(v.bub, v.bub, v.nb) + v.nb);
      b_valid = bv;
      a_data  = a_val(nf);
      b_data  = B_VAL;
      @(negedge clk);
      t = $sformatf("v%0d c%0d", id, c);
      exp_strobe = 1'b0;
      exp_idx    = 0;
      for (int i = 0; i < v.len; i++) begin
        if (fire_cyc(i, v.bub, v.nb) + LAT + 1 == c) begin
          exp_strobe = 1'b1;
          exp_idx    = i;
        end
      end
      if (res_strobe) nstrobe++;
      chk({t, " res_strobe"}, 32'(res_strobe), 32'(exp_strobe));
      if (exp_strobe) chk({t, " res_index"}, 32'(res_index), 32'(exp_idx));
      chk({t, " done"}, 32'(done), 32'(c == v.exp_done));
      chk({t, " busy"}, 32'(busy), 32'(c <= v.exp_done));
      chk({t, " add_ce"}, 32'(add_ce), 32'(c <= v.exp_done));
      chk({t, " a_ready"}, 32'(a_ready), 32'(v.len > 0 && c <= last_f && bv));
      chk({t, " b_ready"}, 32'(b_ready), 32'(v.len > 0 && c <= last_f));
      chk({t, " add_A"}, add_A, (nf > 0) ? a_val(nf - 1) : m_a);
      chk({t, " add_B"}, add_B, (nf > 0) ? B_VAL : m_b);
      chk({t, " add_op"}, 32'(add_op), 32'(v.op));
`ifdef FP_ISSUE_STATS_EN
      if (c == 1) chk({t, " stall_cleared"}, 32'(stall_cycles), 32'd0);
      if (c >= v.exp_done) chk({t, " stall_cycles"}, 32'(stall_cycles), 32'(v.exp_stall));
`endif
    end
    chk($sformatf("v%0d strobe_count", id), 32'(nstrobe), 32'(v.exp_strobes));
    if (v.len > 0) begin
      m_a = a_val(v.len - 1);
      m_b = B_VAL;
    end
    start   = 1'b0;
    vec_len = '0;
    op_in   = 1'b0;
  endtask

  vec_t tbl [6];

  initial begin
    //          len op bub nb rst  strb done stall
    tbl[0] = '{3, 0, -1, 0, 0,  3,   9,   0};  // 1.0,2.0,3.0 + 0.5, no stalls
    tbl[1] = '{4, 0,  0, 2, 0,  4,  12,   2};  // b_valid low 2 cycles after pair 0
    tbl[2] = '{0, 0, -1, 0, 0,  0,   1,   0};  // empty vector
    tbl[3] = '{2, 1,  0, 3, 0,  2,  11,   3};  // subtract, 3 bubble cycles
    tbl[4] = '{8, 0, -1, 0, 3,  8,  14,   0};  // ignored start(len=1,sub) mid-vector
    tbl[5] = '{5, 1,  2, 1, 0,  5,  12,   1};  // single bubble mid-vector

    // Power-on reset
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    for (int k = 0; k < 6; k++) begin
      run_vec(k, tbl[k]);
    end

    // Reset two cycles into a vec_len=8 op aborts everything
    @(posedge clk); #1;
    start   = 1'b1;
    vec_len = LW'(8);
    op_in   = 1'b0;
    a_valid = 1'b1;
    b_valid = 1'b1;
    a_data  = a_val(0);
    @(posedge clk); #1;
    start   = 1'b0;
    a_data  = a_val(1);
    @(posedge clk); #1;
    rst     = 1'b1;
    a_data  = a_val(2);
    @(posedge clk); #1;
    rst     = 1'b0;
    @(negedge clk);
    chk_all_zero("midrst");
    m_a = '0;
    m_b = '0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk($sformatf("midrst+%0d res_strobe", c), 32'(res_strobe), 32'd0);
      chk($sformatf("midrst+%0d busy", c), 32'(busy), 32'd0);
    end

    // Normal operation resumes after the abort
    run_vec(6, tbl[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
